// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the MIPS boot loader.
// The loader uses the slave modport; the byte source / memory side uses master.
interface program_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;

  modport master (
    output byte_valid_i, byte_data_i,
    input  mem_write_o, mem_address_o, mem_data_o
  );

  modport slave (
    input  byte_valid_i, byte_data_i,
    output mem_write_o, mem_address_o, mem_data_o
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses SYNC/LEN_HI/LEN_LO/data frames into big-endian words, writes them to
// program memory and holds the MIPS core in reset until a full image is in. Option: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH = 256,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave bus,
  output logic            cpu_reset_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [15:0]     words_loaded_o
);

  localparam logic [16:0] DEPTH_C = 17'(MEMORY_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // Where a frame goes once its last data byte (or an empty header) has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_FRAME_END = ST_CHECK;
`else
  localparam state_t ST_FRAME_END = ST_DONE;
`endif

  state_t      state_r, state_next_s;
  logic [15:0] count_r, count_next_s;
  logic [1:0]  byte_idx_r, byte_idx_next_s;
  logic [23:0] shift_r, shift_next_s;
  logic [15:0] words_r, words_next_s;
  logic        write_next_s;
  logic [31:0] addr_next_s;
  logic [31:0] data_next_s;
  logic [15:0] len_s;
  logic        last_word_s;

  logic        mem_write_r;
  logic [31:0] mem_address_r;
  logic [31:0] mem_data_r;
  logic        cpu_reset_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  sum_r, sum_next_s;

  function automatic logic [7:0] checksum_add(input logic [7:0] sum, input logic [7:0] data);
    checksum_add = sum + data;
  endfunction
`endif

  function automatic logic state_is_busy(input state_t s);
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: state_is_busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK:                      state_is_busy = 1'b1;
`endif
      default:                       state_is_busy = 1'b0;
    endcase
  endfunction

  assign len_s       = {count_r[15:8], bus.byte_data_i};
  assign last_word_s = ((words_r + 16'd1) == count_r);

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and next-datapath decode; only accepted bytes move anything.
  always_comb begin
    state_next_s    = state_r;
    count_next_s    = count_r;
    byte_idx_next_s = byte_idx_r;
    shift_next_s    = shift_r;
    words_next_s    = words_r;
    write_next_s    = 1'b0;
    addr_next_s     = mem_address_r;
    data_next_s     = mem_data_r;
`ifdef LOADER_CHECKSUM_EN
    sum_next_s      = sum_r;
`endif
    if (bus.byte_valid_i) begin
      case (state_r)
        ST_IDLE, ST_ERROR: begin
          if (bus.byte_data_i == SYNC_BYTE) begin
            state_next_s = ST_LEN_HI;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_LEN_HI: begin
          count_next_s = {bus.byte_data_i, 8'h00};
          state_next_s = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          count_next_s    = len_s;
          byte_idx_next_s = 2'd0;
          words_next_s    = 16'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_next_s      = 8'h00;
`endif
          if ({1'b0, len_s} > DEPTH_C) begin
            state_next_s = ST_ERROR;
          end else if (len_s == 16'd0) begin
            state_next_s = ST_FRAME_END;
          end else begin
            state_next_s = ST_DATA;
          end
        end
        ST_DATA: begin
          shift_next_s    = {shift_r[15:0], bus.byte_data_i};
          byte_idx_next_s = byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_next_s      = checksum_add(sum_r, bus.byte_data_i);
`endif
          // shift_r already holds bytes 0..2 of the word, MSB first.
          if (byte_idx_r == 2'd3) begin
            write_next_s = 1'b1;
            data_next_s  = {shift_r, bus.byte_data_i};
            addr_next_s  = BASE_ADDRESS + {14'd0, words_r, 2'b00};
            words_next_s = words_r + 16'd1;
            if (last_word_s) begin
              state_next_s = ST_FRAME_END;
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (bus.byte_data_i == sum_r) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end
`endif
        ST_DONE: begin
          state_next_s = ST_DONE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Datapath and registered outputs; status flags track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r       <= 16'd0;
      byte_idx_r    <= 2'd0;
      shift_r       <= 24'd0;
      words_r       <= 16'd0;
      mem_write_r   <= 1'b0;
      mem_address_r <= BASE_ADDRESS;
      mem_data_r    <= 32'd0;
      cpu_reset_r   <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_r         <= 8'h00;
`endif
    end else begin
      count_r       <= count_next_s;
      byte_idx_r    <= byte_idx_next_s;
      shift_r       <= shift_next_s;
      words_r       <= words_next_s;
      mem_write_r   <= write_next_s;
      mem_address_r <= addr_next_s;
      mem_data_r    <= data_next_s;
      // Released one cycle after DONE is entered, i.e. after the final write strobe.
      cpu_reset_r   <= (state_r != ST_DONE);
      busy_r        <= state_is_busy(state_next_s);
      done_r        <= (state_next_s == ST_DONE);
      error_r       <= (state_next_s == ST_ERROR);
`ifdef LOADER_CHECKSUM_EN
      sum_r         <= sum_next_s;
`endif
    end
  end

  assign bus.mem_write_o   = mem_write_r;
  assign bus.mem_address_o = mem_address_r;
  assign bus.mem_data_o    = mem_data_r;
  assign cpu_reset_o       = cpu_reset_r;
  assign busy_o            = busy_r;
  assign done_o            = done_r;
  assign error_o           = error_r;
  assign words_loaded_o    = words_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: constant vector table, hand-written timing sequences
// and random frame streams checked against a frame-level parsing model.
module tb_program_loader;
  localparam logic [7:0]  SYNC  = 8'hA5;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_reset_o, busy_o, done_o, error_o;
  logic [15:0] words_loaded_o;

  program_loader_if bus();

  program_loader #(.MEMORY_DEPTH(DEPTH), .SYNC_BYTE(SYNC), .BASE_ADDRESS(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cpu_reset_o(cpu_reset_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .words_loaded_o(words_loaded_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  stim_q[$];
  logic        exp_done, exp_err, exp_busy;
  logic [15:0] exp_words;
  logic        prev_write = 1'b0;

  typedef struct {
    logic [127:0] b;      // frame bytes, left aligned, byte 0 in [127:120]
    int           n;
    logic         cs_en;  // send cs byte when the checksum option is built in
    logic [7:0]   cs;
    int           nw;
    logic [63:0]  w0, w1; // {address, data}
    logic         done, err;
    logic [15:0]  words;
  } vec_t;

  vec_t tbl[5];
  int   ntbl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Write monitor: capture every strobe, require single-cycle pulses with the core held.
  always @(negedge clk) begin
    if (bus.mem_write_o === 1'b1) begin
      obs_q.push_back({bus.mem_address_o, bus.mem_data_o});
      check("write_pulse_width", {63'd0, prev_write}, 64'd0);
      check("cpu_held_during_write", {63'd0, cpu_reset_o}, 64'd1);
    end
    prev_write <= bus.mem_write_o;
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.byte_data_i = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values();
    check("rst_mem_write", {63'd0, bus.mem_write_o}, 64'd0);
    check("rst_mem_address", {32'd0, bus.mem_address_o}, {32'd0, BASE});
    check("rst_mem_data", {32'd0, bus.mem_data_o}, 64'd0);
    check("rst_cpu_reset", {63'd0, cpu_reset_o}, 64'd1);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_error", {63'd0, error_o}, 64'd0);
    check("rst_words", {48'd0, words_loaded_o}, 64'd0);
  endtask

  // Frame-level reference: walk the byte list as frames, not as a per-cycle machine.
  task automatic model(input logic [7:0] s[$]);
    int         i;
    int         n;
    logic [7:0] sum;
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_busy = 1'b0; exp_words = 16'd0;
    i = 0;
    while (i < s.size() && !exp_done && !exp_busy) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      exp_err = 1'b0;
      if (i + 3 > s.size()) begin
        exp_busy = 1'b1;
        break;
      end
      n = {s[i+1], s[i+2]};
      i += 3;
      exp_words = 16'd0;
      sum = 8'h00;
      if (n > DEPTH) begin
        exp_err = 1'b1;
        continue;
      end
      for (int k = 0; k < n; k++) begin
        if (i + 4 > s.size()) begin
          exp_busy = 1'b1;
          break;
        end
        exp_q.push_back({BASE + 32'(4 * k), s[i], s[i+1], s[i+2], s[i+3]});
        sum = sum + s[i] + s[i+1] + s[i+2] + s[i+3];
        exp_words++;
        i += 4;
      end
      if (exp_busy) break;
`ifdef LOADER_CHECKSUM_EN
      if (i >= s.size()) begin
        exp_busy = 1'b1;
        break;
      end
      if (s[i] == sum) exp_done = 1'b1;
      else exp_err = 1'b1;
      i++;
`else
      exp_done = 1'b1;
`endif
    end
  endtask

  task automatic push_frame(input int n, input bit bad);
    logic [7:0] sum;
    logic [7:0] b;
    logic [15:0] len;
    sum = 8'h00;
    len = 16'(n);
    stim_q.push_back(SYNC);
    stim_q.push_back(len[15:8]);
    stim_q.push_back(len[7:0]);
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      sum = sum + b;
      stim_q.push_back(b);
    end
    if (bad) sum = sum ^ 8'h3C;
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(sum);
`endif
  endtask

  task automatic run_stream(input bit with_reset, input int gap_max);
    int nc;
    if (with_reset) do_reset();
    model(stim_q);
    foreach (stim_q[k]) begin
      send_byte(stim_q[k]);
      idle($urandom_range(0, gap_max));
    end
    idle(4);
    check("stream_nwrites", 64'(obs_q.size()), 64'(exp_q.size()));
    nc = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < nc; k++) check("stream_write", obs_q[k], exp_q[k]);
    check("stream_done", {63'd0, done_o}, {63'd0, exp_done});
    check("stream_error", {63'd0, error_o}, {63'd0, exp_err});
    check("stream_busy", {63'd0, busy_o}, {63'd0, exp_busy});
    check("stream_words", {48'd0, words_loaded_o}, {48'd0, exp_words});
    check("stream_cpu_reset", {63'd0, cpu_reset_o}, {63'd0, !exp_done});
  endtask

  initial begin
    logic [127:0] tmp;
    logic [7:0]   b;
    int           n;

    tbl[0] = '{b: {88'hA50002DEADBEEF01234567, 40'h0}, n: 11, cs_en: 1'b1, cs: 8'h08, nw: 2,
               w0: {32'h0040_0000, 32'hDEADBEEF}, w1: {32'h0040_0004, 32'h0123_4567},
               done: 1'b1, err: 1'b0, words: 16'd2};
    tbl[1] = '{b: {80'h00FF5AA5000111223344, 48'h0}, n: 10, cs_en: 1'b1, cs: 8'hAA, nw: 1,
               w0: {32'h0040_0000, 32'h1122_3344}, w1: 64'd0,
               done: 1'b1, err: 1'b0, words: 16'd1};
    tbl[2] = '{b: {24'hA50101, 104'h0}, n: 3, cs_en: 1'b0, cs: 8'h00, nw: 0,
               w0: 64'd0, w1: 64'd0, done: 1'b0, err: 1'b1, words: 16'd0};
    tbl[3] = '{b: {24'hA50000, 104'h0}, n: 3, cs_en: 1'b1, cs: 8'h00, nw: 0,
               w0: 64'd0, w1: 64'd0, done: 1'b1, err: 1'b0, words: 16'd0};
    tbl[4] = '{b: {56'hA5000111223344, 72'h0}, n: 7, cs_en: 1'b1, cs: 8'h55, nw: 1,
               w0: {32'h0040_0000, 32'h1122_3344}, w1: 64'd0,
               done: 1'b0, err: 1'b1, words: 16'd1};
`ifdef LOADER_CHECKSUM_EN
    ntbl = 5;
`else
    ntbl = 4;
`endif

    do_reset();
    check_reset_values();

    for (int v = 0; v < ntbl; v++) begin
      do_reset();
      tmp = tbl[v].b;
      for (int k = 0; k < tbl[v].n; k++) send_byte(tmp[127 - 8 * k -: 8]);
`ifdef LOADER_CHECKSUM_EN
      if (tbl[v].cs_en) send_byte(tbl[v].cs);
`endif
      idle(3);
      check("vec_nwrites", 64'(obs_q.size()), 64'(tbl[v].nw));
      if (tbl[v].nw > 0) check("vec_write0", obs_q[0], tbl[v].w0);
      if (tbl[v].nw > 1) check("vec_write1", obs_q[1], tbl[v].w1);
      check("vec_done", {63'd0, done_o}, {63'd0, tbl[v].done});
      check("vec_error", {63'd0, error_o}, {63'd0, tbl[v].err});
      check("vec_cpu_reset", {63'd0, cpu_reset_o}, {63'd0, !tbl[v].done});
      check("vec_busy", {63'd0, busy_o}, 64'd0);
      check("vec_words", {48'd0, words_loaded_o}, {48'd0, tbl[v].words});
    end

    // Write strobe and core-release timing around the final word.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("tm_no_write_early", {63'd0, bus.mem_write_o}, 64'd0);
    send_byte(8'h44);
    check("tm_write_pulse", {63'd0, bus.mem_write_o}, 64'd1);
    check("tm_write_addr", {32'd0, bus.mem_address_o}, 64'h0040_0000);
    check("tm_write_data", {32'd0, bus.mem_data_o}, 64'h1122_3344);
    check("tm_words", {48'd0, words_loaded_o}, 64'd1);
    check("tm_cpu_held", {63'd0, cpu_reset_o}, 64'd1);
`ifdef LOADER_CHECKSUM_EN
    check("tm_check_busy", {63'd0, busy_o}, 64'd1);
    check("tm_check_not_done", {63'd0, done_o}, 64'd0);
    send_byte(8'hAA);
    check("tm_write_drops", {63'd0, bus.mem_write_o}, 64'd0);
`endif
    check("tm_done", {63'd0, done_o}, 64'd1);
    check("tm_cpu_still_held", {63'd0, cpu_reset_o}, 64'd1);
    idle(1);
    check("tm_cpu_released", {63'd0, cpu_reset_o}, 64'd0);
    check("tm_write_low", {63'd0, bus.mem_write_o}, 64'd0);

    // Reset after the second data byte of word 0, then a full frame from word 0.
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'hDE); send_byte(8'hAD);
    check("mid_busy", {63'd0, busy_o}, 64'd1);
    do_reset();
    check_reset_values();
    stim_q = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(8'h08);
`endif
    run_stream(1'b0, 0);

    // Recovery from an oversize header without reset.
    do_reset();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check("err_set", {63'd0, error_o}, 64'd1);
    check("err_not_busy", {63'd0, busy_o}, 64'd0);
    send_byte(8'h3C);
    check("err_ignores_byte", {63'd0, error_o}, 64'd1);
    send_byte(8'hA5);
    check("err_cleared_by_sync", {63'd0, error_o}, 64'd0);
    check("err_resync_busy", {63'd0, busy_o}, 64'd1);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    idle(2);
    check("err_recover_done", {63'd0, done_o}, 64'd1);
    check("err_recover_nwrites", 64'(obs_q.size()), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum then a corrected frame.
    stim_q = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
               8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    run_stream(1'b1, 1);
    check("cs_retry_done", {63'd0, done_o}, 64'd1);
`endif

    // Largest accepted image.
    stim_q.delete();
    push_frame(DEPTH, 1'b0);
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h00);
    run_stream(1'b1, 0);
    check("n256_words", {48'd0, words_loaded_o}, 64'd256);

    // Random mixes of garbage, good frames, oversize headers and bad-checksum frames.
    for (int it = 0; it < 40; it++) begin
      stim_q.delete();
      repeat ($urandom_range(1, 5)) begin
        case ($urandom_range(0, 4))
          0: repeat ($urandom_range(1, 3)) begin
               b = 8'($urandom);
               if (b == SYNC) b = 8'h5A;
               stim_q.push_back(b);
             end
          1, 2: push_frame($urandom_range(0, 4), 1'b0);
          3: begin
               n = $urandom_range(DEPTH + 1, 65535);
               stim_q.push_back(SYNC);
               stim_q.push_back(8'(n >> 8));
               stim_q.push_back(8'(n));
             end
          default: push_frame($urandom_range(1, 3), 1'b1);
        endcase
      end
      run_stream(1'b1, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
